// File: rtl/vx_mem_arb_pkg.sv
// Shared definitions for the memory arbiter: arbitration type encodings and width helpers.
package vx_mem_arb_pkg;

  localparam string ArbRoundRobin = "R";
  localparam string ArbFixedPrio  = "P";

  // Requester-index bits appended to the tag; a single requester needs none.
  function automatic int unsigned log_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Width of internal index signals; never zero so vectors stay legal.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned tag_out_width(int unsigned tag_in_w, int unsigned n);
    return tag_in_w + log_width(n);
  endfunction

endpackage

// File: rtl/vx_elastic_buffer.sv
// Two-entry elastic (skid) buffer: registered outputs, one-cycle latency, full throughput,
// and an input ready that depends only on local state.
module vx_elastic_buffer #(
  parameter int unsigned DATAW = 1,
  parameter int unsigned SIZE  = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [DATAW-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [DATAW-1:0] data_o
);

  // Only the two-entry (output + skid) organisation is implemented.
  localparam bit SizeOk = (SIZE == 2);

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [DATAW-1:0] out_data_q, out_data_d;
  logic [DATAW-1:0] skid_data_q, skid_data_d;
  logic             push, pop;

  assign ready_o = !skid_valid_q;
  assign push    = valid_i && ready_o;
  assign pop     = out_valid_q && ready_i;

  // Refill the output stage from the skid entry first, else from the input.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) out_data_d = data_i;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = data_i;
    end
  end

  // Occupancy flags are reset; discarding entries is enough on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Payload registers carry no reset.
  always_ff @(posedge clk_i) begin
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

  assign valid_o = out_valid_q;
  assign data_o  = out_data_q;

  size_legal_a: assert property (@(posedge clk_i) SizeOk);

endmodule

// File: rtl/vx_mem_arb.sv
// N-to-1 memory request arbiter with tag-based response routing back to the requesters.
module vx_mem_arb
  import vx_mem_arb_pkg::*;
#(
  parameter int unsigned  NUM_REQS      = 4,
  parameter int unsigned  DATA_WIDTH    = 512,
  parameter int unsigned  ADDR_WIDTH    = 26,
  parameter int unsigned  TAG_IN_WIDTH  = 8,
  parameter string        TYPE          = "R",
  parameter int unsigned  BUFFERED_REQ  = 1,
  parameter int unsigned  BUFFERED_RSP  = 1,
  localparam int unsigned LOG           = log_width(NUM_REQS),
  localparam int unsigned TAG_OUT_WIDTH = tag_out_width(TAG_IN_WIDTH, NUM_REQS),
  localparam int unsigned BYTEEN        = DATA_WIDTH / 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQS-1:0]                    req_valid_in,
  input  logic [NUM_REQS-1:0]                    req_rw_in,
  input  logic [NUM_REQS-1:0][BYTEEN-1:0]        req_byteen_in,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]    req_addr_in,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]    req_data_in,
  input  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]  req_tag_in,
  output logic [NUM_REQS-1:0]                    req_ready_in,
  output logic                                   req_valid_out,
  output logic                                   req_rw_out,
  output logic [BYTEEN-1:0]                      req_byteen_out,
  output logic [ADDR_WIDTH-1:0]                  req_addr_out,
  output logic [DATA_WIDTH-1:0]                  req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]               req_tag_out,
  input  logic                                   req_ready_out,
  input  logic                                   rsp_valid_in,
  input  logic [DATA_WIDTH-1:0]                  rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]               rsp_tag_in,
  output logic                                   rsp_ready_in,
  output logic [NUM_REQS-1:0]                    rsp_valid_out,
  output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]    rsp_data_out,
  output logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]  rsp_tag_out,
  input  logic [NUM_REQS-1:0]                    rsp_ready_out
);

  localparam int unsigned IdxW       = idx_width(NUM_REQS);
  localparam int unsigned ReqW       = 1 + BYTEEN + ADDR_WIDTH + DATA_WIDTH + TAG_OUT_WIDTH;
  localparam int unsigned RspW       = TAG_OUT_WIDTH + DATA_WIDTH;
  localparam bit          RoundRobin = (TYPE == ArbRoundRobin);
  localparam bit          FixedPrio  = (TYPE == ArbFixedPrio);

  // ---------------------------------------------------------------------------------------------
  // Request arbiter
  // ---------------------------------------------------------------------------------------------
  logic [IdxW-1:0]          rr_last_q, rr_last_d;
  logic [IdxW-1:0]          lock_idx_q, lock_idx_d;
  logic                     lock_q, lock_d;
  logic [IdxW-1:0]          rr_start, search_idx, grant_idx;
  logic                     arb_valid, arb_ready, arb_fire;
  logic [TAG_OUT_WIDTH-1:0] arb_tag;
  logic [ReqW-1:0]          arb_payload;

  // Search start: index 0 for fixed priority, one past the last winner for round-robin.
  always_comb begin
    rr_start = '0;
    if (!FixedPrio && (rr_last_q != IdxW'(NUM_REQS - 1))) rr_start = rr_last_q + 1'b1;
  end

  // Walk from the farthest offset down so the nearest asserted requester wins.
  always_comb begin
    int k;
    k          = 0;
    search_idx = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      k = (int'(rr_start) + i) % NUM_REQS;
      if (req_valid_in[k]) search_idx = IdxW'(k);
    end
  end

  // A stalled offer keeps its grant so the downstream payload cannot change under it.
  assign grant_idx = lock_q ? lock_idx_q : search_idx;
  assign arb_valid = req_valid_in[grant_idx];
  assign arb_fire  = arb_valid && arb_ready;

  // Only the granted requester sees ready.
  always_comb begin
    req_ready_in            = '0;
    req_ready_in[grant_idx] = arb_ready;
  end

  if (LOG > 0) begin : g_tag_idx
    assign arb_tag = {req_tag_in[grant_idx], grant_idx[LOG-1:0]};
  end else begin : g_tag_pass
    assign arb_tag = req_tag_in[grant_idx];
  end

  assign arb_payload = {req_rw_in[grant_idx], req_byteen_in[grant_idx], req_addr_in[grant_idx],
                        req_data_in[grant_idx], arb_tag};

  // Pointer advances only on a fire; lock holds while an offer is stalled.
  always_comb begin
    rr_last_d  = rr_last_q;
    if (arb_fire && RoundRobin) rr_last_d = grant_idx;
    lock_d     = arb_valid && !arb_ready;
    lock_idx_d = grant_idx;
  end

  // Arbiter state; reset leaves the pointer on the last index so index 0 goes first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last_q  <= IdxW'(NUM_REQS - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_last_q  <= rr_last_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Request path stage
  // ---------------------------------------------------------------------------------------------
  logic            req_out_valid;
  logic [ReqW-1:0] req_out_payload;

  if (BUFFERED_REQ != 0) begin : g_req_buf
    vx_elastic_buffer #(
      .DATAW (ReqW),
      .SIZE  (2)
    ) u_req_buf (
      .clk_i   (clk),
      .rst_ni  (reset),
      .valid_i (arb_valid),
      .ready_o (arb_ready),
      .data_i  (arb_payload),
      .valid_o (req_out_valid),
      .ready_i (req_ready_out),
      .data_o  (req_out_payload)
    );
  end else begin : g_req_comb
    assign req_out_valid   = arb_valid;
    assign arb_ready       = req_ready_out;
    assign req_out_payload = arb_payload;
  end

  assign req_valid_out = req_out_valid;
  assign {req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out} = req_out_payload;

  // ---------------------------------------------------------------------------------------------
  // Response path stage and demux
  // ---------------------------------------------------------------------------------------------
  logic                     dmx_valid, dmx_ready;
  logic [RspW-1:0]          dmx_payload;
  logic [TAG_OUT_WIDTH-1:0] dmx_tag;
  logic [DATA_WIDTH-1:0]    dmx_data;
  logic [IdxW-1:0]          dmx_idx;

  if (BUFFERED_RSP != 0) begin : g_rsp_buf
    vx_elastic_buffer #(
      .DATAW (RspW),
      .SIZE  (2)
    ) u_rsp_buf (
      .clk_i   (clk),
      .rst_ni  (reset),
      .valid_i (rsp_valid_in),
      .ready_o (rsp_ready_in),
      .data_i  ({rsp_tag_in, rsp_data_in}),
      .valid_o (dmx_valid),
      .ready_i (dmx_ready),
      .data_o  (dmx_payload)
    );
  end else begin : g_rsp_comb
    assign dmx_valid    = rsp_valid_in;
    assign rsp_ready_in = dmx_ready;
    assign dmx_payload  = {rsp_tag_in, rsp_data_in};
  end

  assign {dmx_tag, dmx_data} = dmx_payload;

  if (LOG > 0) begin : g_rsp_idx
    assign dmx_idx = dmx_tag[LOG-1:0];
  end else begin : g_rsp_single
    assign dmx_idx = '0;
  end

  // Route to the requester named in the tag LSBs; data and tag are broadcast, valid is not.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_valid_out[i] = dmx_valid && (dmx_idx == IdxW'(i));
      rsp_data_out[i]  = dmx_data;
      rsp_tag_out[i]   = dmx_tag[TAG_OUT_WIDTH-1 -: TAG_IN_WIDTH];
    end
  end

  assign dmx_ready = rsp_ready_out[dmx_idx];

  // Index field can only be out of range when NUM_REQS is not a power of two.
  if (NUM_REQS != (1 << LOG)) begin : g_idx_check
    rsp_idx_legal_a: assert property (@(posedge clk) disable iff (!reset)
      rsp_valid_in |-> (int'(rsp_tag_in[LOG-1:0]) < NUM_REQS));
  end

  type_legal_a: assert property (@(posedge clk) RoundRobin || FixedPrio);

endmodule

// File: tb/tb_vx_mem_arb.sv
// Directed bench for vx_mem_arb: round-robin and fixed-priority instances share the inputs.
module tb_vx_mem_arb;

  localparam int N   = 4;
  localparam int DW  = 512;
  localparam int AW  = 26;
  localparam int TIW = 8;
  localparam int TOW = 10;
  localparam int BE  = 64;

  logic                   clk, reset;
  logic [N-1:0]           req_valid_in, req_rw_in, req_ready_in, p_req_ready_in;
  logic [N-1:0][BE-1:0]   req_byteen_in;
  logic [N-1:0][AW-1:0]   req_addr_in;
  logic [N-1:0][DW-1:0]   req_data_in;
  logic [N-1:0][TIW-1:0]  req_tag_in;
  logic                   req_valid_out, req_rw_out, p_req_valid_out, p_req_rw_out;
  logic [BE-1:0]          req_byteen_out, p_req_byteen_out;
  logic [AW-1:0]          req_addr_out, p_req_addr_out;
  logic [DW-1:0]          req_data_out, p_req_data_out;
  logic [TOW-1:0]         req_tag_out, p_req_tag_out;
  logic                   req_ready_out;
  logic                   rsp_valid_in, rsp_ready_in, p_rsp_ready_in;
  logic [DW-1:0]          rsp_data_in;
  logic [TOW-1:0]         rsp_tag_in;
  logic [N-1:0]           rsp_valid_out, p_rsp_valid_out, rsp_ready_out;
  logic [N-1:0][DW-1:0]   rsp_data_out, p_rsp_data_out;
  logic [N-1:0][TIW-1:0]  rsp_tag_out, p_rsp_tag_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tag_tab [N];

  typedef struct {
    logic [N-1:0] valid;
    logic         mem_rdy;
    logic [N-1:0] exp_rdy;
    logic         exp_vout;
    int           exp_idx;
  } vec_t;

  vec_t vecs [6];

  localparam logic [DW-1:0] RspD0 = {16{32'hCAFE_0296}};
  localparam logic [DW-1:0] RspD1 = {16{32'h1111_0001}};
  localparam logic [DW-1:0] RspD2 = {16{32'h2222_0002}};
  localparam logic [DW-1:0] RspD3 = {16{32'h3333_0003}};

  vx_mem_arb #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TIW),
    .TYPE("R"), .BUFFERED_REQ(1), .BUFFERED_RSP(1)
  ) u_dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_byteen_in(req_byteen_in),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_in(req_ready_in),
    .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_byteen_out(req_byteen_out),
    .req_addr_out(req_addr_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
    .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out),
    .rsp_ready_out(rsp_ready_out)
  );

  vx_mem_arb #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TIW),
    .TYPE("P"), .BUFFERED_REQ(1), .BUFFERED_RSP(1)
  ) u_dut_p (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_byteen_in(req_byteen_in),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_in(p_req_ready_in),
    .req_valid_out(p_req_valid_out), .req_rw_out(p_req_rw_out),
    .req_byteen_out(p_req_byteen_out), .req_addr_out(p_req_addr_out),
    .req_data_out(p_req_data_out), .req_tag_out(p_req_tag_out),
    .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
    .rsp_ready_in(p_rsp_ready_in),
    .rsp_valid_out(p_rsp_valid_out), .rsp_data_out(p_rsp_data_out),
    .rsp_tag_out(p_rsp_tag_out), .rsp_ready_out(rsp_ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [TOW-1:0] etag(input int idx);
    return {tag_tab[idx], 2'(idx)};
  endfunction

  function automatic logic [DW-1:0] edata(input int idx);
    return {16{32'hD000_0000 | 32'(idx)}};
  endfunction

  task automatic clear_inputs();
    req_valid_in  = '0;
    req_ready_out = 1'b0;
    rsp_valid_in  = 1'b0;
    rsp_tag_in    = '0;
    rsp_data_in   = '0;
    rsp_ready_out = '0;
  endtask

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    #1;
    chk("reset_req_valid_out", req_valid_out, 1'b0);
    chk("reset_rsp_valid_out", rsp_valid_out, 4'h0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      tag_tab[i] = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : (i == 2) ? 8'hA5 : 8'h33;
      req_tag_in[i]    = tag_tab[i];
      req_addr_in[i]   = 26'h100 + 26'(i);
      req_data_in[i]   = edata(i);
      req_byteen_in[i] = {BE{1'b1}} ^ BE'(i);
      req_rw_in[i]     = i[0];
    end
    clear_inputs();

    // All requesters valid, memory always ready: grants rotate 0,1,2,3,0.
    vecs[0] = '{4'hF, 1'b1, 4'h1, 1'b0, 0};
    vecs[1] = '{4'hF, 1'b1, 4'h2, 1'b1, 0};
    vecs[2] = '{4'hF, 1'b1, 4'h4, 1'b1, 1};
    vecs[3] = '{4'hF, 1'b1, 4'h8, 1'b1, 2};
    vecs[4] = '{4'hF, 1'b1, 4'h1, 1'b1, 3};
    vecs[5] = '{4'hF, 1'b1, 4'h2, 1'b1, 0};

    @(negedge clk);
    do_reset();

    for (int v = 0; v < 6; v++) begin
      req_valid_in  = vecs[v].valid;
      req_ready_out = vecs[v].mem_rdy;
      #1;
      chk($sformatf("rr%0d_ready_in", v), req_ready_in, vecs[v].exp_rdy);
      chk($sformatf("rr%0d_valid_out", v), req_valid_out, vecs[v].exp_vout);
      if (vecs[v].exp_vout) begin
        chk($sformatf("rr%0d_tag_out", v), req_tag_out, etag(vecs[v].exp_idx));
        chk($sformatf("rr%0d_addr_out", v), req_addr_out, 26'h100 + 26'(vecs[v].exp_idx));
        chk($sformatf("rr%0d_data_out", v), req_data_out, edata(vecs[v].exp_idx));
        if (vecs[v].exp_idx == 2) chk("rr_tag_0x296", req_tag_out, 10'h296);
      end
      next_cycle();
    end

    // Stall: req 1 then req 3 enter the buffer, memory not ready, output must hold.
    do_reset();
    req_valid_in = 4'b1010;
    req_ready_out = 1'b0;
    #1;
    chk("stall_first_grant", req_ready_in, 4'b0010);
    chk("stall_vout_empty", req_valid_out, 1'b0);
    next_cycle();
    req_valid_in = 4'b1000;
    #1;
    chk("stall_second_grant", req_ready_in, 4'b1000);
    chk("stall_tag_req1", req_tag_out, 10'h089);
    next_cycle();
    for (int h = 0; h < 4; h++) begin
      req_valid_in = 4'b0001;
      #1;
      chk($sformatf("hold%0d_ready_in", h), req_ready_in, 4'b0000);
      chk($sformatf("hold%0d_valid_out", h), req_valid_out, 1'b1);
      chk($sformatf("hold%0d_tag_out", h), req_tag_out, 10'h089);
      chk($sformatf("hold%0d_addr_out", h), req_addr_out, 26'h101);
      next_cycle();
    end
    req_ready_out = 1'b1;
    #1;
    chk("release_ready_in_full", req_ready_in, 4'b0000);
    chk("release_tag_req1", req_tag_out, 10'h089);
    next_cycle();
    #1;
    chk("release_tag_req3", req_tag_out, 10'h0CF);
    chk("release_grant_req0", req_ready_in, 4'b0001);
    next_cycle();
    req_valid_in = 4'b0000;
    #1;
    chk("release_tag_req0", req_tag_out, 10'h044);
    next_cycle();
    #1;
    chk("release_drained", req_valid_out, 1'b0);

    // Response routing, with a request firing in the same cycle.
    do_reset();
    req_valid_in  = 4'b0001;
    req_ready_out = 1'b1;
    rsp_valid_in  = 1'b1;
    rsp_tag_in    = 10'h296;
    rsp_data_in   = RspD0;
    rsp_ready_out = 4'b0100;
    #1;
    chk("rsp_ready_in_empty", rsp_ready_in, 1'b1);
    chk("both_req_ready_in", req_ready_in, 4'b0001);
    chk("rsp_valid_out_empty", rsp_valid_out, 4'b0000);
    next_cycle();
    req_valid_in = 4'b0000;
    rsp_valid_in = 1'b0;
    #1;
    chk("rsp_route_valid", rsp_valid_out, 4'b0100);
    chk("rsp_route_tag", rsp_tag_out[2], 8'hA5);
    chk("rsp_route_data", rsp_data_out[2], RspD0);
    chk("both_req_tag_out", req_tag_out, 10'h044);
    next_cycle();
    #1;
    chk("rsp_route_drained", rsp_valid_out, 4'b0000);
    chk("both_req_drained", req_valid_out, 1'b0);

    // Response backpressure: two accepted, then ready drops, drain in order.
    rsp_ready_out = 4'b0000;
    rsp_valid_in  = 1'b1;
    rsp_tag_in    = 10'h006;
    rsp_data_in   = RspD1;
    #1;
    chk("bp0_ready_in", rsp_ready_in, 1'b1);
    next_cycle();
    rsp_tag_in  = 10'h00A;
    rsp_data_in = RspD2;
    #1;
    chk("bp1_ready_in", rsp_ready_in, 1'b1);
    chk("bp1_valid_out", rsp_valid_out, 4'b0100);
    next_cycle();
    rsp_tag_in  = 10'h00E;
    rsp_data_in = RspD3;
    #1;
    chk("bp2_ready_in_full", rsp_ready_in, 1'b0);
    chk("bp2_tag_first", rsp_tag_out[2], 8'h01);
    next_cycle();
    rsp_ready_out = 4'b0100;
    #1;
    chk("bp3_ready_in_full", rsp_ready_in, 1'b0);
    chk("bp3_tag_first", rsp_tag_out[2], 8'h01);
    chk("bp3_data_first", rsp_data_out[2], RspD1);
    next_cycle();
    #1;
    chk("bp4_ready_in", rsp_ready_in, 1'b1);
    chk("bp4_tag_second", rsp_tag_out[2], 8'h02);
    chk("bp4_data_second", rsp_data_out[2], RspD2);
    next_cycle();
    rsp_valid_in = 1'b0;
    #1;
    chk("bp5_tag_third", rsp_tag_out[2], 8'h03);
    chk("bp5_data_third", rsp_data_out[2], RspD3);
    next_cycle();
    #1;
    chk("bp6_drained", rsp_valid_out, 4'b0000);

    // Fixed priority: requesters 0 and 3 valid throughout, 0 always wins.
    do_reset();
    req_valid_in  = 4'b1001;
    req_ready_out = 1'b1;
    for (int s = 0; s < 4; s++) begin
      #1;
      chk($sformatf("prio%0d_ready_in", s), p_req_ready_in, 4'b0001);
      chk($sformatf("prio%0d_valid_out", s), p_req_valid_out, (s != 0));
      if (s != 0) chk($sformatf("prio%0d_tag_out", s), p_req_tag_out, 10'h044);
      next_cycle();
    end

    // Reset with both buffers full: outputs drop at once, order restarts at 0.
    do_reset();
    req_valid_in  = 4'b1111;
    req_ready_out = 1'b0;
    rsp_valid_in  = 1'b1;
    rsp_tag_in    = 10'h296;
    rsp_data_in   = RspD0;
    rsp_ready_out = 4'b0000;
    next_cycle();
    next_cycle();
    #1;
    chk("full_req_ready_in", req_ready_in, 4'b0000);
    chk("full_rsp_ready_in", rsp_ready_in, 1'b0);
    chk("full_req_valid_out", req_valid_out, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst_req_valid_out", req_valid_out, 1'b0);
    chk("midrst_rsp_valid_out", rsp_valid_out, 4'b0000);
    chk("midrst_rsp_ready_in", rsp_ready_in, 1'b1);
    next_cycle();
    reset         = 1'b1;
    rsp_valid_in  = 1'b0;
    req_ready_out = 1'b1;
    #1;
    chk("post_rst_grant0", req_ready_in, 4'b0001);
    next_cycle();
    #1;
    chk("post_rst_tag0", req_tag_out, 10'h044);
    chk("post_rst_grant1", req_ready_in, 4'b0010);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
